// File: rtl/rv_exec_md.sv
// rv_exec_md -- execute stage of the in-order RV pipeline.
//
// Holds the decode->execute stage register and drives the single-cycle ALU,
// the operand muxes and branch/jump target resolution from it. RV32M
// multiply/divide ops go to an iterative unit. While that unit works, o_stall
// holds fetch/decode and this stage register. Bubbles are sent to the memory
// stage until the result is ready.
//
// Build option: define RV_EXEC_FAST_MUL_EN to replace the iterative multiplier
// with one registered XLEN x XLEN product (the divider is unchanged).
//
// Ports
//   i_clk, i_reset            clock; synchronous active-high reset
//   i_flush                   kill stage contents and any in-flight mul/div
//   i_pc, i_pc_p4             word PC / PC+4 of the incoming instruction
//   i_rs1_val, i_rs2_val      forwarded operands for the instruction in this stage
//   i_rd, i_imm               destination register, immediate
//   i_reg_write .. i_res_src  decode controls
//   i_funct3, i_alu_ctrl      funct3 (M op select), ALU op code
//   i_md_valid                instruction is an RV32M op
//   o_stall                   hold upstream stages and this stage register
//   o_alu_result              ALU or mul/div result
//   o_reg_write/o_mem_*       controls to memory stage, forced 0 while stalling
//   o_rd .. o_rs2_val         pass-through to memory stage
//   o_pc_src, o_pc_target     redirect taken / redirect word target
//
// ALU op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
// 8 OR, 9 AND, 10 EQ, 11 NE, 12 GE, 13 GEU, 14 pass operand 2.
// Operand 1 select: 0 zero, 1 rs1, 2 pc. Operand 2 select: 0 imm, 1 rs2.
// A cleared stage register therefore computes 0 + 0 on every output.
module rv_exec_md #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic [XLEN-3:0] i_pc,
    input  logic [XLEN-3:0] i_pc_p4,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_reg_write,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic            i_jump,
    input  logic            i_branch,
    input  logic            i_pc_sel,
    input  logic            i_alu_op2_sel,
    input  logic [1:0]      i_alu_op1_sel,
    input  logic [1:0]      i_res_src,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_alu_ctrl,
    input  logic            i_md_valid,
    output logic            o_stall,
    output logic [XLEN-1:0] o_alu_result,
    output logic            o_reg_write,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic [4:0]      o_rd,
    output logic [1:0]      o_res_src,
    output logic [2:0]      o_funct3,
    output logic [XLEN-3:0] o_pc_p4,
    output logic [XLEN-1:0] o_rs2_val,
    output logic            o_pc_src,
    output logic [XLEN-3:0] o_pc_target
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN / DIV_BITS - 1);
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR  = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR  = 5'd8,  ALU_AND  = 5'd9,  ALU_EQ  = 5'd10, ALU_NE   = 5'd11;
    localparam logic [4:0] ALU_GE  = 5'd12, ALU_GEU  = 5'd13, ALU_OP2 = 5'd14;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    // Shift-add: add the multiplicand once per set bit of this digit.
    function automatic logic [2*XLEN-1:0] mul_iter(input logic [2*XLEN-1:0] acc,
                                                   input logic [2*XLEN-1:0] mcand,
                                                   input logic [MUL_BITS-1:0] digit);
        for (int i = 0; i < MUL_BITS; i++) begin
            if (digit[i]) acc = acc + (mcand << i);
        end
        return acc;
    endfunction

    // Restoring division, DIV_BITS quotient bits. Returns {remainder, quotient}.
    function automatic logic [2*XLEN:0] div_iter(input logic [XLEN:0]   rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
        for (int i = 0; i < DIV_BITS; i++) begin
            rem = {rem[XLEN-1:0], quo[XLEN-1]};
            quo = {quo[XLEN-2:0], 1'b0};
            if (rem >= {1'b0, dvs}) begin
                rem    = rem - {1'b0, dvs};
                quo[0] = 1'b1;
            end
        end
        return {rem, quo};
    endfunction

    // The unit works on magnitudes. This restores the sign and picks the result word.
    function automatic logic [XLEN-1:0] md_fixup(input logic [2:0]        op,
                                                 input logic              neg,
                                                 input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   quo);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        prod = neg ? -acc : acc;
        q    = neg ? -quo : quo;
        r    = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        case (op)
            3'd0:          return prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: return prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:    return q;
            default:       return r;
        endcase
    endfunction

    // ---- Stage p1: decode -> execute register ----
    logic [XLEN-3:0] pc_p1, pc_p4_p1;
    logic [XLEN-1:0] imm_p1;
    logic [4:0]      rd_p1, alu_ctrl_p1;
    logic            reg_write_p1, mem_read_p1, mem_write_p1, jump_p1, branch_p1;
    logic            pc_sel_p1, op2_sel_p1, md_vld_p1;
    logic [1:0]      op1_sel_p1, res_src_p1;
    logic [2:0]      funct3_p1;
    logic            stall;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            pc_p1 <= '0;        pc_p4_p1 <= '0;     imm_p1 <= '0;
            rd_p1 <= '0;        alu_ctrl_p1 <= '0;  reg_write_p1 <= 1'b0;
            mem_read_p1 <= 1'b0; mem_write_p1 <= 1'b0; jump_p1 <= 1'b0;
            branch_p1 <= 1'b0;  pc_sel_p1 <= 1'b0;  op2_sel_p1 <= 1'b0;
            md_vld_p1 <= 1'b0;  op1_sel_p1 <= '0;   res_src_p1 <= '0;
            funct3_p1 <= '0;
        end else if (!stall) begin
            pc_p1 <= i_pc;             pc_p4_p1 <= i_pc_p4;       imm_p1 <= i_imm;
            rd_p1 <= i_rd;             alu_ctrl_p1 <= i_alu_ctrl; reg_write_p1 <= i_reg_write;
            mem_read_p1 <= i_mem_read; mem_write_p1 <= i_mem_write; jump_p1 <= i_jump;
            branch_p1 <= i_branch;     pc_sel_p1 <= i_pc_sel;     op2_sel_p1 <= i_alu_op2_sel;
            md_vld_p1 <= i_md_valid;   op1_sel_p1 <= i_alu_op1_sel; res_src_p1 <= i_res_src;
            funct3_p1 <= i_funct3;
        end
    end

    // ---- Stage p1: single-cycle ALU and redirect ----
    logic [XLEN-1:0] op1, op2, alu_res;
    logic [SH_W-1:0] shamt;

    always_comb begin
        case (op1_sel_p1)
            2'd1:    op1 = i_rs1_val;
            2'd2:    op1 = {pc_p1, 2'b00};
            default: op1 = '0;
        endcase
        op2   = op2_sel_p1 ? i_rs2_val : imm_p1;
        shamt = op2[SH_W-1:0];
        case (alu_ctrl_p1)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_SLL:  alu_res = op1 << shamt;
            ALU_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
            ALU_SLTU: alu_res = XLEN'(op1 < op2);
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_SRL:  alu_res = op1 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op1) >>> shamt);
            ALU_OR:   alu_res = op1 | op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_EQ:   alu_res = XLEN'(op1 == op2);
            ALU_NE:   alu_res = XLEN'(op1 != op2);
            ALU_GE:   alu_res = XLEN'($signed(op1) >= $signed(op2));
            ALU_GEU:  alu_res = XLEN'(op1 >= op2);
            ALU_OP2:  alu_res = op2;
            default:  alu_res = '0;
        endcase
    end

    // ---- Stage p1: iterative mul/div unit ----
    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] a_q, a_d;      // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]   b_q, b_d;      // multiplier digits, or divisor
    logic [2*XLEN-1:0] acc_q, acc_d;  // product, or remainder in [XLEN:0]
    logic              neg_q, neg_d;
    logic [2:0]        op_q, op_d;
    logic              rs1_sgn, rs2_sgn;
    logic [XLEN-1:0]   abs1, abs2;
    logic [2*XLEN:0]   div_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        op_d    = op_q;
        stall   = 1'b0;
        // rs1 is unsigned only for MULHU/DIVU/REMU; rs2 is signed for MUL/MULH/DIV/REM.
        rs1_sgn = i_rs1_val[XLEN-1] & ~(funct3_p1 == 3'd3 || funct3_p1 == 3'd5 || funct3_p1 == 3'd7);
        rs2_sgn = i_rs2_val[XLEN-1] & (funct3_p1 == 3'd0 || funct3_p1 == 3'd1 ||
                                       funct3_p1 == 3'd4 || funct3_p1 == 3'd6);
        abs1    = rs1_sgn ? -i_rs1_val : i_rs1_val;
        abs2    = rs2_sgn ? -i_rs2_val : i_rs2_val;
        div_nxt = div_iter(acc_q[XLEN:0], a_q[XLEN-1:0], b_q);
        case (state_q)
            IDLE: begin
                if (md_vld_p1) begin
                    stall   = 1'b1;
                    op_d    = funct3_p1;
                    a_d     = {{XLEN{1'b0}}, abs1};
                    b_d     = abs2;
                    acc_d   = '0;
                    state_d = BUSY;
                    if (funct3_p1[2]) begin
                        neg_d = funct3_p1[1] ? rs1_sgn : (rs1_sgn ^ rs2_sgn);
                        cnt_d = DIV_LAST;
                        // Early-outs are staged so the DONE fix-up yields the
                        // architectural result without a separate result path.
                        if (i_rs2_val == '0) begin
                            a_d     = {{XLEN{1'b0}}, {XLEN{1'b1}}};
                            acc_d   = {{XLEN{1'b0}}, abs1};
                            neg_d   = funct3_p1[1] & rs1_sgn;
                            cnt_d   = '0;
                            state_d = DONE;
                        end else if (!funct3_p1[0] && i_rs1_val == XMIN && (&i_rs2_val)) begin
                            a_d     = {{XLEN{1'b0}}, XMIN};
                            neg_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = DONE;
                        end
                    end else begin
                        neg_d = rs1_sgn ^ rs2_sgn;
`ifdef RV_EXEC_FAST_MUL_EN
                        acc_d   = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
                        cnt_d   = '0;
                        state_d = DONE;
`else
                        cnt_d   = CNT_W'(XLEN / MUL_BITS - 1);
`endif
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (op_q[2]) begin
                    acc_d = {{(XLEN-1){1'b0}}, div_nxt[2*XLEN:XLEN]};
                    a_d   = {{XLEN{1'b0}}, div_nxt[XLEN-1:0]};
                end else begin
                    acc_d = mul_iter(acc_q, a_q, b_q[MUL_BITS-1:0]);
                    a_d   = a_q << MUL_BITS;
                    b_d   = b_q >> MUL_BITS;
                end
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        neg_q <= neg_d;
        op_q  <= op_d;
    end

    // ---- Stage p1 -> memory stage outputs ----
    assign o_stall      = stall;
    assign o_alu_result = (state_q == DONE) ? md_fixup(op_q, neg_q, acc_q, a_q[XLEN-1:0]) : alu_res;
    assign o_reg_write  = reg_write_p1 & ~stall;
    assign o_mem_read   = mem_read_p1 & ~stall;
    assign o_mem_write  = mem_write_p1 & ~stall;
    assign o_pc_src     = (jump_p1 | (branch_p1 & alu_res[0])) & ~stall;
    assign o_pc_target  = (pc_sel_p1 ? i_rs1_val[XLEN-1:2] : pc_p1) + imm_p1[XLEN-1:2];
    assign o_rd         = rd_p1;
    assign o_res_src    = res_src_p1;
    assign o_funct3     = funct3_p1;
    assign o_pc_p4      = pc_p4_p1;
    assign o_rs2_val    = i_rs2_val;
endmodule

// File: tb/tb_rv_exec_md.sv
// Scoreboard bench for rv_exec_md: directed instructions push their expected
// writeback into a queue; a monitor pops one entry per cycle with o_reg_write.
module tb_rv_exec_md;
    localparam int XLEN = 32;

    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLTU = 5'd4, A_SRA = 5'd7, A_EQ = 5'd10;
    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

`ifdef RV_EXEC_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 9;
`endif

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic            i_reset, i_flush;
    logic [XLEN-3:0] i_pc, i_pc_p4;
    logic [XLEN-1:0] i_rs1_val, i_rs2_val, i_imm;
    logic [4:0]      i_rd, i_alu_ctrl;
    logic            i_reg_write, i_mem_read, i_mem_write, i_jump, i_branch, i_pc_sel, i_alu_op2_sel;
    logic [1:0]      i_alu_op1_sel, i_res_src;
    logic [2:0]      i_funct3;
    logic            i_md_valid;
    logic            o_stall, o_reg_write, o_mem_read, o_mem_write, o_pc_src;
    logic [XLEN-1:0] o_alu_result, o_rs2_val;
    logic [4:0]      o_rd;
    logic [1:0]      o_res_src;
    logic [2:0]      o_funct3;
    logic [XLEN-3:0] o_pc_p4, o_pc_target;

    rv_exec_md #(.XLEN(XLEN), .MUL_BITS(4), .DIV_BITS(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_pc(i_pc), .i_pc_p4(i_pc_p4), .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val),
        .i_rd(i_rd), .i_imm(i_imm), .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_jump(i_jump), .i_branch(i_branch), .i_pc_sel(i_pc_sel),
        .i_alu_op2_sel(i_alu_op2_sel), .i_alu_op1_sel(i_alu_op1_sel), .i_res_src(i_res_src),
        .i_funct3(i_funct3), .i_alu_ctrl(i_alu_ctrl), .i_md_valid(i_md_valid),
        .o_stall(o_stall), .o_alu_result(o_alu_result), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_rd(o_rd), .o_res_src(o_res_src),
        .o_funct3(o_funct3), .o_pc_p4(o_pc_p4), .o_rs2_val(o_rs2_val), .o_pc_src(o_pc_src),
        .o_pc_target(o_pc_target)
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] res;
        int              tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bubble();
        i_alu_ctrl = '0; i_alu_op1_sel = '0; i_alu_op2_sel = 1'b0; i_imm = '0; i_rd = '0;
        i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_jump = 1'b0;
        i_branch = 1'b0; i_pc_sel = 1'b0; i_res_src = '0; i_funct3 = '0; i_md_valid = 1'b0;
        i_pc = 30'h40; i_pc_p4 = 30'h41;
    endtask

    // Issue one instruction, supply its operands while it sits in the stage,
    // scramble the operands after the start cycle, and count stall cycles.
    task automatic run_instr(input int tag, input logic [4:0] alu, input logic md, input logic [2:0] f3,
                             input logic [1:0] op1sel, input logic op2sel, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm, input logic [4:0] rd,
                             input logic [XLEN-1:0] exp_res, input int exp_stall);
        int n;
        exp_t e;
        bubble();
        i_alu_ctrl = alu; i_md_valid = md; i_funct3 = f3; i_alu_op1_sel = op1sel;
        i_alu_op2_sel = op2sel; i_imm = imm; i_rd = rd; i_reg_write = 1'b1;
        @(posedge i_clk); #1;
        bubble();
        i_rs1_val = a; i_rs2_val = b;
        e.rd = rd; e.res = exp_res; e.tag = tag;
        sb.push_back(e);
        n = 0;
        while (o_stall === 1'b1 && n < 100) begin
            @(posedge i_clk); #1;
            n++;
            i_rs1_val = $urandom; i_rs2_val = $urandom;
        end
        check($sformatf("stall_cycles[%0d]", tag), 64'(n), 64'(exp_stall));
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_stall) check("bubble_ctrl", 64'({o_reg_write, o_mem_read, o_mem_write, o_pc_src}), 64'd0);
            if (o_reg_write) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got writeback rd=%0d result=0x%0h, required none", o_rd, o_alu_result);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("wb_result[%0d]", mon_e.tag), 64'(o_alu_result), 64'(mon_e.res));
                    check($sformatf("wb_rd[%0d]", mon_e.tag), 64'(o_rd), 64'(mon_e.rd));
                end
            end
        end
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL timeout: run still active at 100000 ns, required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles with busy-looking inputs.
        i_reset = 1'b1; i_flush = 1'b0;
        i_alu_ctrl = A_ADD; i_alu_op1_sel = 2'd1; i_alu_op2_sel = 1'b1; i_imm = 32'h10; i_rd = 5'd9;
        i_reg_write = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b1; i_jump = 1'b1; i_branch = 1'b1;
        i_pc_sel = 1'b1; i_res_src = 2'd2; i_funct3 = 3'd5; i_md_valid = 1'b1;
        i_pc = 30'h123; i_pc_p4 = 30'h124; i_rs1_val = 32'h1111; i_rs2_val = 32'h2222;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_alu_result", 64'(o_alu_result), 64'd0);
        check("rst_ctrl", 64'({o_reg_write, o_mem_read, o_mem_write, o_pc_src}), 64'd0);
        check("rst_passthru", 64'({o_rd, o_res_src, o_funct3}), 64'd0);
        check("rst_pc_p4", 64'(o_pc_p4), 64'd0);
        check("rst_pc_target", 64'(o_pc_target), 64'd0);
        check("rst_rs2_val", 64'(o_rs2_val), 64'h2222);
        bubble();
        i_reset = 1'b0;
        mon_en  = 1'b1;

        // tag alu  md f3 op1 op2 rs1 rs2 imm rd expected stall
        run_instr(1,  A_ADD, 0, 3'd0,     2'd1, 1, 32'd5,        32'd7,        32'd0,        5'd1,  32'd12,       0);
        run_instr(2,  A_SUB, 0, 3'd0,     2'd1, 1, 32'd5,        32'd7,        32'd0,        5'd2,  32'hFFFFFFFE, 0);
        run_instr(3,  A_SRA, 0, 3'd0,     2'd1, 1, 32'h80000000, 32'd4,        32'd0,        5'd3,  32'hF8000000, 0);
        run_instr(4,  A_ADD, 0, 3'd0,     2'd1, 0, 32'd10,       32'd0,        32'hFFFFFFFF, 5'd4,  32'd9,        0);
        run_instr(5,  A_SLTU,0, 3'd0,     2'd1, 1, 32'd1,        32'hFFFFFFFF, 32'd0,        5'd5,  32'd1,        0);
        run_instr(6,  A_ADD, 1, F_DIV,    2'd1, 1, 32'hFFFFFFEC, 32'd3,        32'd0,        5'd6,  32'hFFFFFFFA, 33);
        run_instr(7,  A_ADD, 1, F_REM,    2'd1, 1, 32'hFFFFFFEC, 32'd3,        32'd0,        5'd7,  32'hFFFFFFFE, 33);
        run_instr(8,  A_ADD, 1, F_DIVU,   2'd1, 1, 32'h1234,     32'd0,        32'd0,        5'd8,  32'hFFFFFFFF, 1);
        run_instr(9,  A_ADD, 1, F_DIV,    2'd1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        5'd9,  32'h80000000, 1);
        run_instr(10, A_ADD, 1, F_REM,    2'd1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        5'd10, 32'd0,        1);
        run_instr(11, A_ADD, 1, F_REM,    2'd1, 1, 32'hFFFFFFFB, 32'd0,        32'd0,        5'd11, 32'hFFFFFFFB, 1);
        run_instr(12, A_ADD, 1, F_MULHU,  2'd1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        5'd12, 32'hFFFFFFFE, MUL_STALL);
        run_instr(13, A_ADD, 1, F_MUL,    2'd1, 1, 32'hFFFFFFFD, 32'd7,        32'd0,        5'd13, 32'hFFFFFFEB, MUL_STALL);
        run_instr(14, A_ADD, 1, F_MULH,   2'd1, 1, 32'h80000000, 32'd2,        32'd0,        5'd14, 32'hFFFFFFFF, MUL_STALL);
        run_instr(15, A_ADD, 1, F_MULHSU, 2'd1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        5'd15, 32'hFFFFFFFF, MUL_STALL);
        run_instr(16, A_ADD, 1, F_DIVU,   2'd1, 1, 32'd100,      32'd7,        32'd0,        5'd16, 32'd14,       33);
        run_instr(17, A_ADD, 1, F_REMU,   2'd1, 1, 32'd100,      32'd7,        32'd0,        5'd17, 32'd2,        33);
        run_instr(18, A_ADD, 1, F_DIV,    2'd1, 1, 32'd7,        32'hFFFFFFFD, 32'd0,        5'd18, 32'hFFFFFFFE, 33);
        run_instr(19, A_ADD, 1, F_REM,    2'd1, 1, 32'd7,        32'hFFFFFFFD, 32'd0,        5'd19, 32'd1,        33);

        // Branch: BEQ at word pc 0x100 with byte offset 0x20.
        bubble();
        i_alu_ctrl = A_EQ; i_alu_op1_sel = 2'd1; i_alu_op2_sel = 1'b1; i_branch = 1'b1;
        i_pc = 30'h100; i_imm = 32'h20;
        @(posedge i_clk); #1;
        bubble();
        i_rs1_val = 32'd9; i_rs2_val = 32'd9;
        #1;
        check("beq_taken", 64'(o_pc_src), 64'd1);
        check("beq_target", 64'(o_pc_target), 64'h108);
        i_rs2_val = 32'd8;
        #1;
        check("beq_not_taken", 64'(o_pc_src), 64'd0);

        // Register-based jump: target from rs1 plus imm.
        i_jump = 1'b1; i_pc_sel = 1'b1; i_imm = 32'h10;
        @(posedge i_clk); #1;
        bubble();
        i_rs1_val = 32'h1000;
        #1;
        check("jalr_taken", 64'(o_pc_src), 64'd1);
        check("jalr_target", 64'(o_pc_target), 64'h404);

        // Flush a DIV in its fifth BUSY cycle; it must never write back.
        bubble();
        i_alu_ctrl = A_ADD; i_md_valid = 1'b1; i_funct3 = F_DIV; i_alu_op1_sel = 2'd1;
        i_alu_op2_sel = 1'b1; i_rd = 5'd20; i_reg_write = 1'b1;
        @(posedge i_clk); #1;
        bubble();
        i_rs1_val = 32'd1000; i_rs2_val = 32'd7;
        repeat (5) @(posedge i_clk);
        #1;
        check("flush_busy_stall", 64'(o_stall), 64'd1);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush_stall_clear", 64'(o_stall), 64'd0);
        check("flush_no_wb", 64'(o_reg_write), 64'd0);
        run_instr(21, A_ADD, 0, 3'd0, 2'd1, 1, 32'd1, 32'd2, 32'd0, 5'd21, 32'd3, 0);

        bubble();
        repeat (3) @(posedge i_clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
